// File: rtl/fft_power_avg.sv
// Per-bin power averager over 2^LOG2_N frames with a sequential peak-bin scan.
// Optional peak-hold outputs when FFT_PWR_AVG_PEAK_HOLD_EN is defined.
module fft_power_avg #(
   parameter int W       = 8,
   parameter int LOG2_N  = 2,
   parameter int SKIP_DC = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pwr_valid,
   input  logic signed [2*W+2:0] pwr_0,
   input  logic signed [2*W+2:0] pwr_1,
   input  logic signed [2*W+2:0] pwr_2,
   input  logic signed [2*W+2:0] pwr_3,
   input  logic signed [2*W+2:0] pwr_4,
   input  logic signed [2*W+2:0] pwr_5,
   input  logic signed [2*W+2:0] pwr_6,
   input  logic signed [2*W+2:0] pwr_7,
   input  logic signed [2*W+2:0] pwr_8,
   input  logic signed [2*W+2:0] pwr_9,
   input  logic signed [2*W+2:0] pwr_10,
   input  logic signed [2*W+2:0] pwr_11,
   input  logic signed [2*W+2:0] pwr_12,
   input  logic signed [2*W+2:0] pwr_13,
   input  logic signed [2*W+2:0] pwr_14,
   input  logic signed [2*W+2:0] pwr_15,
   input  logic signed [2*W+2:0] pwr_16,
   output logic        [2*W+2:0] avg_0,
   output logic        [2*W+2:0] avg_1,
   output logic        [2*W+2:0] avg_2,
   output logic        [2*W+2:0] avg_3,
   output logic        [2*W+2:0] avg_4,
   output logic        [2*W+2:0] avg_5,
   output logic        [2*W+2:0] avg_6,
   output logic        [2*W+2:0] avg_7,
   output logic        [2*W+2:0] avg_8,
   output logic        [2*W+2:0] avg_9,
   output logic        [2*W+2:0] avg_10,
   output logic        [2*W+2:0] avg_11,
   output logic        [2*W+2:0] avg_12,
   output logic        [2*W+2:0] avg_13,
   output logic        [2*W+2:0] avg_14,
   output logic        [2*W+2:0] avg_15,
   output logic        [2*W+2:0] avg_16,
   output logic                  avg_valid,
   output logic [4:0]            peak_bin,
   output logic        [2*W+2:0] peak_pwr,
   output logic                  peak_valid,
   output logic                  scan_ovr
`ifdef FFT_PWR_AVG_PEAK_HOLD_EN
   ,
   input  logic                  hold_clr,
   output logic [4:0]            hold_bin,
   output logic        [2*W+2:0] hold_pwr
`endif
);

   localparam int PW    = 2*W+3;
   localparam int AW    = PW+LOG2_N;
   localparam int CW    = (LOG2_N > 0) ? LOG2_N : 1;
   localparam int NBINS = 17;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   logic [PW-1:0] pwr_in [NBINS];
   logic [PW-1:0] pwr_c  [NBINS];
   logic [AW-1:0] sum    [NBINS];
   logic [AW-1:0] acc_q  [NBINS];
   logic [PW-1:0] avg_q  [NBINS];
   logic [CW-1:0] cnt_q;
   logic          complete;

   state_t        state_q, state_d;
   logic [4:0]    idx_q, best_bin_q, cand_bin;
   logic [PW-1:0] best_pwr_q, cand_pwr, cur_pwr;
   logic          last, finish, abort;

   assign pwr_in[0]  = pwr_0;
   assign pwr_in[1]  = pwr_1;
   assign pwr_in[2]  = pwr_2;
   assign pwr_in[3]  = pwr_3;
   assign pwr_in[4]  = pwr_4;
   assign pwr_in[5]  = pwr_5;
   assign pwr_in[6]  = pwr_6;
   assign pwr_in[7]  = pwr_7;
   assign pwr_in[8]  = pwr_8;
   assign pwr_in[9]  = pwr_9;
   assign pwr_in[10] = pwr_10;
   assign pwr_in[11] = pwr_11;
   assign pwr_in[12] = pwr_12;
   assign pwr_in[13] = pwr_13;
   assign pwr_in[14] = pwr_14;
   assign pwr_in[15] = pwr_15;
   assign pwr_in[16] = pwr_16;

   assign avg_0  = avg_q[0];
   assign avg_1  = avg_q[1];
   assign avg_2  = avg_q[2];
   assign avg_3  = avg_q[3];
   assign avg_4  = avg_q[4];
   assign avg_5  = avg_q[5];
   assign avg_6  = avg_q[6];
   assign avg_7  = avg_q[7];
   assign avg_8  = avg_q[8];
   assign avg_9  = avg_q[9];
   assign avg_10 = avg_q[10];
   assign avg_11 = avg_q[11];
   assign avg_12 = avg_q[12];
   assign avg_13 = avg_q[13];
   assign avg_14 = avg_q[14];
   assign avg_15 = avg_q[15];
   assign avg_16 = avg_q[16];

   // Negative powers clamp to zero; with LOG2_N=0 the counter never leaves 0.
   always_comb begin
      for (int unsigned k = 0; k < NBINS; k++) begin
         pwr_c[k] = pwr_in[k][PW-1] ? '0 : pwr_in[k];
         sum[k]   = acc_q[k] + AW'(pwr_c[k]);
      end
   end

   assign complete = pwr_valid && (cnt_q == CW'((1 << LOG2_N) - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < NBINS; k++) begin
            acc_q[k] <= '0;
            avg_q[k] <= '0;
         end
         cnt_q     <= '0;
         avg_valid <= 1'b0;
      end else begin
         avg_valid <= 1'b0;
         if (pwr_valid) begin
            if (complete) begin
               for (int unsigned k = 0; k < NBINS; k++) begin
                  avg_q[k] <= PW'(sum[k] >> LOG2_N);
                  acc_q[k] <= '0;
               end
               cnt_q     <= '0;
               avg_valid <= 1'b1;
            end else begin
               for (int unsigned k = 0; k < NBINS; k++)
                  acc_q[k] <= sum[k];
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign cur_pwr  = avg_q[idx_q];
   assign cand_pwr = (cur_pwr > best_pwr_q) ? cur_pwr : best_pwr_q;
   assign cand_bin = (cur_pwr > best_pwr_q) ? idx_q : best_bin_q;
   assign last     = (idx_q == 5'd16);
   assign abort    = avg_valid && (state_q != IDLE);

   // Result is registered on the last SCAN edge so peak_valid is visible in DONE;
   // it is withheld if a new average lands in that DONE cycle (which aborts).
   assign finish = (state_q == SCAN) && !avg_valid && last && !complete;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (avg_valid) state_d = SCAN;
         SCAN:    if (!avg_valid && last) state_d = DONE;
         DONE:    state_d = avg_valid ? SCAN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q      <= '0;
         best_bin_q <= '0;
         best_pwr_q <= '0;
         peak_bin   <= '0;
         peak_pwr   <= '0;
         peak_valid <= 1'b0;
         scan_ovr   <= 1'b0;
      end else begin
         peak_valid <= 1'b0;
         if (abort) scan_ovr <= 1'b1;
         if (avg_valid) begin
            idx_q      <= 5'(SKIP_DC);
            best_bin_q <= 5'(SKIP_DC);
            best_pwr_q <= '0;
         end else if (state_q == SCAN) begin
            idx_q      <= idx_q + 5'd1;
            best_bin_q <= cand_bin;
            best_pwr_q <= cand_pwr;
         end
         if (finish) begin
            peak_bin   <= cand_bin;
            peak_pwr   <= cand_pwr;
            peak_valid <= 1'b1;
         end
      end
   end

`ifdef FFT_PWR_AVG_PEAK_HOLD_EN
   always_ff @(posedge clk) begin
      if (rst || hold_clr) begin
         hold_bin <= '0;
         hold_pwr <= '0;
      end else if (finish && (cand_pwr > hold_pwr)) begin
         hold_bin <= cand_bin;
         hold_pwr <= cand_pwr;
      end
   end
`endif

endmodule

// File: doc/fft_power_avg.md
Name: fft_power_avg

Overview:
- Sits directly downstream of the per-bin FFT power stage. Consumes the 17 one-sided bin powers (bins 0..16 of a 32-point FFT).
- Averages each bin over 2^LOG2_N valid frames, then scans the averaged spectrum sequentially for the peak bin.
- Feeds the testbench scoreboard and the spectral-check logic.

Parameters:
W, 8, FFT output sample width; each input power is 2*W+3 bits signed.
LOG2_N, 2, log2 of frames averaged; legal range 0..8.
SKIP_DC, 1, 1 = exclude bin 0 from the peak search; 0 = include it.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
pwr_valid  input  1  frame strobe; pwr_0..pwr_16 are sampled only when this is 1
pwr_0 .. pwr_16  input  2*W+3 each, signed  per-bin power from the upstream stage
avg_0 .. avg_16  output  2*W+3 each, unsigned  averaged per-bin power, registered
avg_valid  output  1  one-cycle pulse when avg_* update
peak_bin  output  5  index of the maximum averaged bin
peak_pwr  output  2*W+3  averaged power at peak_bin
peak_valid  output  1  one-cycle pulse when peak_* update
scan_ovr  output  1  sticky flag: a peak scan was aborted by a new average

Behaviour:
- Reset: one clock and one reset. rst is synchronous and active-high; all state is sampled on the rising edge of clk.
  - While rst=1 at a clock edge, clear all accumulators, the frame counter, avg_*, avg_valid, peak_bin, peak_pwr, peak_valid and scan_ovr to 0, and put the FSM in IDLE.
  - A reset mid-accumulation or mid-scan discards all partial state.
- Input clamp: a pwr_k with MSB=1 is treated as 0. Otherwise the value is used as unsigned.
- Accumulation:
  - 17 accumulators, each 2*W+3+LOG2_N bits wide, with no overflow possible.
  - A frame counter of LOG2_N bits counts valid frames only. Cycles with pwr_valid=0 leave all state unchanged.
- Average completion: on the valid frame where the counter equals 2^LOG2_N-1:
  - avg_k <= (acc_k + pwr_k) >> LOG2_N, truncating.
  - Accumulators and the counter clear to 0.
  - avg_valid = 1 on the next cycle for exactly one cycle.
  - If LOG2_N=0, every valid frame completes an average.
- Latency: an average completed at cycle t gives avg_* and avg_valid visible at t+1.
- Peak FSM, states IDLE -> SCAN -> DONE -> IDLE:
  - IDLE -> SCAN on avg_valid. Load idx = SKIP_DC, best_pwr = 0, best_bin = SKIP_DC.
  - SCAN examines one bin per cycle, reading avg_idx. It replaces best only if avg_idx > best_pwr (strictly), so ties keep the lowest index.
  - SCAN exits after bin 16.
  - DONE: peak_bin <= best_bin, peak_pwr <= best_pwr, peak_valid = 1 for one cycle, then IDLE.
  - peak_valid asserts NB+1 cycles after avg_valid, where NB = 17-SKIP_DC.
- Simultaneous events:
  - avg_valid while in SCAN or DONE aborts the current scan. No peak_valid is produced for the old average.
  - scan_ovr is set, and the scan restarts on the new average.
  - scan_ovr clears only on rst.
- All-zero spectrum: peak_bin = SKIP_DC, peak_pwr = 0.

Optional Feature:
- Macro FFT_PWR_AVG_PEAK_HOLD_EN.
- When defined, add:
  - output hold_bin (5 bits) and hold_pwr (2*W+3 bits);
  - input hold_clr (1 bit).
- On each peak_valid, if peak_pwr > hold_pwr, load hold_pwr/hold_bin from peak_pwr/peak_bin, updating on the same edge as peak_*.
- hold_clr=1 zeroes both on the next edge, and wins over a simultaneous update. rst also zeroes both.
- When undefined, these ports and registers do not exist. Core behaviour is identical either way.

Test Plan:
1. Reset: drive random pwr_*, pwr_valid=1, rst=1 for 3 cycles -> all outputs 0, no avg_valid/peak_valid pulse.
2. W=8, LOG2_N=2, SKIP_DC=1: 4 consecutive frames with pwr_k=100*k -> one avg_valid pulse on the cycle after frame 4, avg_k=100*k; peak_valid 17 cycles later with peak_bin=16, peak_pwr=1600.
3. Truncation and gaps: bin 3 = 1,2,3,5 over 4 valid frames with 2 idle cycles between frames 2 and 3 -> avg_3=2; avg_valid timing follows frame 4 only.
4. Tie and DC: bin0=900, bins 5 and 9 =500, others 10 -> SKIP_DC=1 gives peak_bin=5, peak_pwr=500; SKIP_DC=0 gives peak_bin=0, peak_pwr=900.
5. Clamp and reset mid-operation: frame with pwr_2 MSB set counts as 0; assert rst after 2 frames, then 4 frames of pwr_k=8 -> avg_k=8 (pre-reset frames excluded).
6. Overrun: LOG2_N=0, pwr_valid=1 every cycle -> avg_valid every cycle after the first, peak_valid never asserts, scan_ovr=1 and stays 1 until rst.
